// File: rtl/mac_ctrl_pkg.sv
// Shared constants for the MAC bias-add control path: sequencer state
// encoding and default datapath widths.
package mac_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int BIAS_WIDTH_DEF = 16;
    localparam int CH_NUM_DEF     = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_XFER  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/mac_bias_sequencer.sv
// Frame controller pairing each channel's MAC result with its bias word and
// handing the pair to the bias-add unit; counts returns to detect frame end.
module mac_bias_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  BIAS_WIDTH = BIAS_WIDTH_DEF,
    parameter int  CH_NUM     = CH_NUM_DEF,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  mac_valid,
    output logic                  mac_ready,
    input  logic [DATA_WIDTH-1:0] mac_in,
    output logic                  bias_rd_en,
    output logic [CH_W-1:0]       bias_rd_addr,
    input  logic [BIAS_WIDTH-1:0] bias_rd_data,
    output logic                  bu_valid_in,
    output logic [DATA_WIDTH-1:0] bu_mac_data,
    output logic [BIAS_WIDTH-1:0] bu_bias_data,
    input  logic                  bu_valid_out,
    output logic [CH_W-1:0]       ch_idx
);

    localparam int              CNT_W    = $clog2(CH_NUM + 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CH_NUM);

    state_t                  state_reg, state_next;
    logic [CH_W-1:0]         ch_reg;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    err_reg;
    logic                    done_reg;
    logic                    ign_reg;
    logic [BIAS_WIDTH-1:0]   bias_reg;
    logic                    bu_valid_reg;
    logic [DATA_WIDTH-1:0]   bu_mac_reg;
    logic [BIAS_WIDTH-1:0]   bu_bias_reg;

    logic start_acc;
    logic hs;
    logic ret;
    logic err_set;

    assign start_acc = (state_reg == ST_IDLE) && start;
    assign hs        = (state_reg == ST_XFER) && mac_valid;
    // A return still in flight when reset is released must not count or flag.
    assign ret       = bu_valid_out && !ign_reg;
    assign err_set   = ret && (!busy || (cnt_reg == CNT_FULL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_XFER;
            ST_XFER:  if (mac_valid) state_next = (ch_reg == CH_LAST) ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: if (cnt_next == CNT_FULL) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != ST_IDLE);
        mac_ready  = (state_reg == ST_XFER);
        bias_rd_en = (state_reg == ST_FETCH);
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (start_acc) begin
            cnt_next = '0;
        end else if (ret && busy && (cnt_reg != CNT_FULL)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_reg   <= '0;
            cnt_reg  <= '0;
            err_reg  <= 1'b0;
            done_reg <= 1'b0;
            ign_reg  <= 1'b1;
        end else begin
            ign_reg  <= 1'b0;
            cnt_reg  <= cnt_next;
            // Done must coincide with the return to IDLE so busy drops with it.
            done_reg <= (state_reg == ST_DRAIN) && (cnt_next == CNT_FULL);
            if (start_acc) begin
                ch_reg <= '0;
            end else if (hs && (ch_reg != CH_LAST)) begin
                ch_reg <= ch_reg + 1'b1;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (start_acc) begin
                err_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_reg     <= '0;
            bu_valid_reg <= 1'b0;
            bu_mac_reg   <= '0;
            bu_bias_reg  <= '0;
        end else begin
            if (state_reg == ST_LOAD) begin
                bias_reg <= bias_rd_data;
            end
            bu_valid_reg <= hs;
            if (hs) begin
                bu_mac_reg  <= mac_in;
                bu_bias_reg <= bias_reg;
            end
        end
    end

    assign done         = done_reg;
    assign err          = err_reg;
    assign bias_rd_addr = ch_reg;
    assign ch_idx       = ch_reg;
    assign bu_valid_in  = bu_valid_reg;
    assign bu_mac_data  = bu_mac_reg;
    assign bu_bias_data = bu_bias_reg;

endmodule

// File: doc/mac_bias_sequencer.md
# mac_bias_sequencer

Frame-level controller that drives the MAC bias-add stage. For each of CH_NUM output channels it:
- fetches the channel's bias from a synchronous bias memory,
- accepts one MAC result from the upstream MAC array (valid/ready),
- presents the aligned {mac, bias} pair to the bias-add unit as a one-cycle valid pulse.

It counts returned results from the bias-add unit and signals frame completion. It sits between the MAC array, the bias memory and the bias-add unit.

## Interface
- DATA_WIDTH, 16, MAC result width
- BIAS_WIDTH, 16, bias word width
- CH_NUM, 8, channels per frame (>=1); CH_W = max(1, $clog2(CH_NUM)) is a localparam
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame start request, sampled when IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on frame completion
- err  out  1  sticky protocol error; cleared by accepted start
- mac_valid  in  1  upstream MAC result valid
- mac_ready  out  1  sequencer accepts MAC result
- mac_in  in  DATA_WIDTH  MAC result
- bias_rd_en  out  1  bias memory read strobe
- bias_rd_addr  out  CH_W  bias address = current channel
- bias_rd_data  in  BIAS_WIDTH  valid the cycle after bias_rd_en
- bu_valid_in  out  1  to bias-add unit
- bu_mac_data  out  DATA_WIDTH  to bias-add unit
- bu_bias_data  out  BIAS_WIDTH  to bias-add unit
- bu_valid_out  in  1  result-valid return from bias-add unit (1-cycle unit latency)
- ch_idx  out  CH_W  channel currently being sequenced

## Operation
- States: IDLE, FETCH, LOAD, XFER, DRAIN.
- **IDLE:** start=1 → FETCH. Clears ch to 0, the return count and err.
- **FETCH:** bias_rd_en=1, bias_rd_addr=ch → LOAD.
- **LOAD:** capture bias_rd_data into the bias register → XFER.
- **XFER:**
  - mac_ready=1.
  - On mac_valid&&mac_ready, register bu_mac_data=mac_in and bu_bias_data=bias register; bu_valid_in=1 in the following cycle only.
  - If ch==CH_NUM-1 → DRAIN, else ch+1 → FETCH.
  - mac_valid low: hold in XFER indefinitely.
- **DRAIN:** wait until the return count reaches CH_NUM → IDLE, with done=1 for that one cycle.
- **Return count:** increments on every bu_valid_out while busy, saturating at CH_NUM.
- **err (sticky):** set by bu_valid_out while not busy, or by bu_valid_out when the count already equals CH_NUM.
- **Data handling:** pure pass-through, no arithmetic. bu_mac_data and bu_bias_data hold their last values when bu_valid_in=0.
- **ch wrap:** ch never exceeds CH_NUM-1; it resets to 0 on the next accepted start.
- **CH_NUM=1:** single FETCH/LOAD/XFER, then DRAIN.

## Timing
- **Reset values** (all outputs): state=IDLE, busy=0, done=0, err=0, mac_ready=0, bias_rd_en=0, bias_rd_addr=0, bu_valid_in=0, bu_mac_data=0, bu_bias_data=0, ch_idx=0.
- **Reset mid-frame:** aborts the frame immediately; no done; pending bias-unit results are ignored and do not set err (err is already 0).
- **Start latency:** start sampled at edge N → FETCH and busy during cycle N+1, LOAD at N+2, XFER (mac_ready=1) at N+3.
- **Handshake latency:** handshake at edge M → bu_valid_in during cycle M+1; the bias-add unit's bu_valid_out returns during M+2.
- **Throughput:** minimum 3 cycles per channel.
- **Frame completion:** done asserts in the cycle after the final bu_valid_out is sampled. busy falls in that same cycle.
- **Back-to-back frames:** start is accepted in the done cycle (state is IDLE).
- **start while busy:** ignored, no side effect.
- **mac_ready:** combinational from state only; never depends on mac_valid.

## Structure
- Shared package mac_ctrl_pkg holds:
  - state encoding localparams (IDLE=0…DRAIN=4, 3 bits),
  - default DATA_WIDTH/BIAS_WIDTH/CH_NUM constants used across the MAC path.
- No sub-module. The bias-add unit and bias memory are instantiated by the parent; this block is one FSM plus the channel counter, return counter and data registers.

## Test plan
- **Reset:** rst pulse mid-XFER, async between edges → all outputs at reset values immediately; next start runs a clean frame.
- **Nominal frame:** CH_NUM=4, bias mem {10, -3, 0, 0x7FFF}, mac_valid held high with mac_in 100, 200, -50, 1 → pairs (100,10), (200,-3), (-50,0), (1,0x7FFF) each as a single bu_valid_in pulse. Each pair is 3 cycles apart; done 2 cycles after the last handshake; err=0.
- **Backpressure:** mac_valid low for 5 cycles in XFER for ch 2 → FSM holds, ch_idx=2, no bu_valid_in. Completes normally once valid rises.
- **Start collisions:** start asserted every cycle → second start accepted exactly on the done cycle; starts during busy are ignored; ch restarts at 0.
- **Protocol error:** bu_valid_out injected while IDLE → err=1, held until the next start, which clears it. A spurious fifth return with CH_NUM=4 → err=1.
- **Single-channel frame:** CH_NUM=1 → one read at address 0; done at cycle N+6 for start at N with mac_valid already high.
